// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FIFO placed behind a UART receiver.
// Stores words written by the receiver's done tick. The head entry is always
// presented on r_data, so it is readable without a pop. A sticky overflow flag
// records any word dropped while the FIFO was full. clr_ovf clears the flag.
// Optional feature: define UART_RX_FIFO_ALMOST_FULL_EN to add a registered
// almost_full output, asserted when count >= AF_LEVEL.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  input  logic              clr_ovf,
  output logic [DBIT-1:0]   r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam int unsigned      DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              ovf_q;
  logic              do_rd;
  logic              do_wr;
  logic              ovf_evt;

  // Status flags come only from the registered count, never from wr/rd.
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  assign overflow = ovf_q;
  assign r_data   = mem[rd_ptr];

  // Decide which operations take effect this cycle and the next count.
  // A pop frees the head slot while full, so a same-cycle write is accepted
  // into that slot and no overflow is raised.
  always_comb begin
    do_rd      = rd & ~empty;
    do_wr      = wr & (~full | do_rd);
    ovf_evt    = wr & full & ~rd;
    count_next = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && do_wr)
      mem[wr_ptr] <= w_data;
  end

  // Pointers, count and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      if (ovf_evt)
        ovf_q <= 1'b1;
      else if (clr_ovf)
        ovf_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);

  // Almost-full is registered from the next count so it tracks count exactly.
  always_ff @(posedge clk) begin
    if (reset)
      almost_full <= 1'b0;
    else
      almost_full <= (count_next >= AF_CNT);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with a queue-based model.
// Define UART_RX_FIFO_ALMOST_FULL_EN for both files to exercise almost_full.
module tb_uart_rx_fifo;

  localparam int DBIT     = 8;
  localparam int ADDR_W   = 4;
  localparam int AF_LEVEL = 12;
  localparam int DEPTH    = 1 << ADDR_W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wr = 1'b0;
  logic [DBIT-1:0] w_data = '0;
  logic            rd = 1'b0;
  logic            clr_ovf = 1'b0;
  logic [DBIT-1:0] r_data;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic            almost_full;
`endif

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .w_data(w_data),
    .rd(rd),
    .clr_ovf(clr_ovf),
    .r_data(r_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words plus a sticky flag.
  logic [DBIT-1:0] q[$];
  bit              m_ovf = 0;
  bit              m_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf  = 0;
      m_live = 1;
    end else if (m_live) begin
      int  sz;
      bit  pop;
      bit  push;
      sz   = q.size();
      pop  = rd && (sz > 0);
      push = wr && ((sz < DEPTH) || pop);
      if (wr && sz == DEPTH && !rd) m_ovf = 1;
      else if (clr_ovf)             m_ovf = 0;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(w_data);
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("count", int'(count), q.size());
      check("empty", int'(empty), int'(q.size() == 0));
      check("full", int'(full), int'(q.size() == DEPTH));
      check("overflow", int'(overflow), int'(m_ovf));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      check("almost_full", int'(almost_full), int'(q.size() >= AF_LEVEL));
`endif
      if (q.size() > 0)
        check("r_data", int'(r_data), int'(q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DBIT-1:0] d);
    wr = 1'b1; w_data = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);

    // Three words in, three out, in order.
    push(8'hA5); push(8'h3C); push(8'h7E);
    check("t1_count3", int'(count), 3);
    check("t1_head0", int'(r_data), 8'hA5);
    pop(); check("t1_head1", int'(r_data), 8'h3C);
    pop(); check("t1_head2", int'(r_data), 8'h7E);
    pop();
    check("t1_count0", int'(count), 0);
    check("t1_empty", int'(empty), 1);

    // Fill, overflow, drain: the dropped 0xFF must never appear.
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t2_full", int'(full), 1);
    check("t2_ovf_before", int'(overflow), 0);
    push(8'hFF);
    check("t2_ovf", int'(overflow), 1);
    check("t2_count16", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", int'(r_data), i);
      pop();
    end
    check("t2_empty", int'(empty), 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t2_clr", int'(overflow), 0);

    // Simultaneous write and pop while full.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    wr = 1'b1; rd = 1'b1; w_data = 8'h55;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("t3_count16", int'(count), 16);
    check("t3_ovf0", int'(overflow), 0);
    for (int i = 1; i < 16; i++) begin
      check("t3_drain", int'(r_data), 8'h20 + i);
      pop();
    end
    check("t3_last", int'(r_data), 8'h55);
    pop();
    check("t3_empty", int'(empty), 1);

    // Simultaneous write and pop while empty; then a pop on empty.
    wr = 1'b1; rd = 1'b1; w_data = 8'h99;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("t4_count1", int'(count), 1);
    check("t4_data", int'(r_data), 8'h99);
    pop();
    pop();
    check("t4_empty_pop", int'(count), 0);
    check("t4_empty_ovf", int'(overflow), 0);

    // Wrap the pointers, then reset mid-stream with other strobes active.
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h40 + i));
      if (i % 2 == 1) pop();
    end
    check("t5_count10", int'(count), 10);
    reset = 1'b1; wr = 1'b1; rd = 1'b1; w_data = 8'hEE;
    tick();
    reset = 1'b0; wr = 1'b0; rd = 1'b0;
    check("t5_rst_count", int'(count), 0);
    check("t5_rst_empty", int'(empty), 1);
    check("t5_rst_ovf", int'(overflow), 0);
    push(8'h11);
    check("t5_first", int'(r_data), 8'h11);
    pop();

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    do_reset();
    for (int i = 0; i < 11; i++) push(8'(i));
    check("t6_af11", int'(almost_full), 0);
    push(8'h0B);
    check("t6_af12", int'(almost_full), 1);
    pop();
    check("t6_af_pop", int'(almost_full), 0);
`endif

    // Overflow wins over a same-cycle clear.
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    wr = 1'b1; clr_ovf = 1'b1; w_data = 8'hCC;
    tick();
    wr = 1'b0; clr_ovf = 1'b0;
    check("t7_ovf_prio", int'(overflow), 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t7_ovf_clr", int'(overflow), 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
